// File: rtl/ram2_index_writer_pkg.sv
// ---------------------------------------------------------------------------
// ram2_index_writer_pkg
// Shared definitions for the RAM2 index writer stage of the compress path:
// controller state encodings, lane geometry of the min-register beat, and
// the byte-serializer state codes.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ram2_index_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LOAD_CB  = 2'b01,
        ST_COMPRESS = 2'b10,
        ST_FINISH   = 2'b11
    } ctrl_state_e;

    localparam int LANES      = 8;
    localparam int POS_W      = 3;
    localparam int DIST_W     = 10;
    localparam int POS_BUS_W  = LANES * POS_W;
    localparam int DIST_BUS_W = LANES * DIST_W;
    // Sum of eight 10-bit lane distances fits in 13 bits.
    localparam int LANE_SUM_W = DIST_W + $clog2(LANES);

    // S_Bk means byte k of the current beat is on the RAM2 outputs.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_B0   = 2'b01,
        S_B1   = 2'b10,
        S_B2   = 2'b11
    } ser_state_e;

endpackage

// File: rtl/ram2_index_writer_if.sv
// ---------------------------------------------------------------------------
// ram2_index_writer_if
// Bundles the beat input from the min-register stage, the RAM2 byte-write
// bus and the status lines returned to the controller.
//   state_in, RAM2_WE_reg_out_in, RAM2_A_reg_out_in, pos_bus_in, dist_bus_in
//     : beat and controller state, driven by the master side
//   RAM2_WE, RAM2_A, RAM2_D : byte writes to RAM2, driven by the slave side
//   stall_out, overflow, distortion_sum, done : status, driven by the slave
// ---------------------------------------------------------------------------
interface ram2_index_writer_if #(
    parameter int ADDR_W = 20,
    parameter int ACC_W  = 32
);
    import ram2_index_writer_pkg::*;

    logic [1:0]            state_in;
    logic                  RAM2_WE_reg_out_in;
    logic [ADDR_W-1:0]     RAM2_A_reg_out_in;
    logic [POS_BUS_W-1:0]  pos_bus_in;
    logic [DIST_BUS_W-1:0] dist_bus_in;

    logic                  RAM2_WE;
    logic [ADDR_W-1:0]     RAM2_A;
    logic [7:0]            RAM2_D;
    logic                  stall_out;
    logic                  overflow;
    logic [ACC_W-1:0]      distortion_sum;
    logic                  done;

    modport master (
        output state_in, RAM2_WE_reg_out_in, RAM2_A_reg_out_in, pos_bus_in, dist_bus_in,
        input  RAM2_WE, RAM2_A, RAM2_D, stall_out, overflow, distortion_sum, done
    );

    modport slave (
        input  state_in, RAM2_WE_reg_out_in, RAM2_A_reg_out_in, pos_bus_in, dist_bus_in,
        output RAM2_WE, RAM2_A, RAM2_D, stall_out, overflow, distortion_sum, done
    );

endinterface

// File: rtl/ram2_index_writer_beat_fifo.sv
// ---------------------------------------------------------------------------
// ram2_index_writer_beat_fifo
// Synchronous FIFO holding accepted beats until the byte serializer takes
// them. Show-ahead read: dout is the head entry whenever empty=0.
//   clk, rst (async, active-low) : clock / reset of pointers and count
//   push, din                    : write an entry (ignored when full)
//   pop                          : retire the head entry (ignored when empty)
//   dout, full, empty, count     : head entry and occupancy
// ---------------------------------------------------------------------------
module ram2_index_writer_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram2_index_writer.sv
// ---------------------------------------------------------------------------
// ram2_index_writer
// Buffers registered beats from the min-register stage, writes each beat's
// 24-bit packed codeword index to RAM2 as three consecutive bytes at
// 3*beat_addr+k, accumulates total quantization distortion, and reports
// stall / overflow / done to the controller.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : ram2_index_writer_if.slave (beat in, RAM2 byte bus and status out)
// ---------------------------------------------------------------------------
module ram2_index_writer
    import ram2_index_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 20,
    parameter int ACC_W      = 32
) (
    input logic               clk,
    input logic               rst,
    ram2_index_writer_if.slave bus
);
    localparam int ENTRY_W = ADDR_W + POS_BUS_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [LANE_SUM_W-1:0] inc);
        logic [ACC_W:0] wide;
        wide = {1'b0, acc} + (ACC_W+1)'(inc);
        return wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] times3(input logic [ADDR_W-1:0] a);
        return (a << 1) + a;
    endfunction

    logic                  beat_in_compress;
    logic                  accept;
    logic                  drop;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic [CNT_W-1:0]      fifo_count;
    logic [ADDR_W-1:0]     head_addr;
    logic [POS_BUS_W-1:0]  head_pos;
    logic [LANE_SUM_W-1:0] lane_sum;

    ser_state_e            ser_q, ser_d;
    logic [ADDR_W-1:0]     base_p1, base_d;
    logic [POS_BUS_W-1:0]  pos_p1, pos_d;
    logic                  vld_p1, vld_d;
    logic [ADDR_W-1:0]     addr_p1, addr_d;
    logic [7:0]            data_p1, data_d;

    logic [ACC_W-1:0]      sum_q;
    logic                  overflow_q;
    logic                  done_q;
    logic                  done_fired_q;
    logic                  done_cond;

    // Stage 0: beat acceptance into the FIFO. A full FIFO drops the beat
    // even if the serializer pops on the same edge.
    assign beat_in_compress = bus.RAM2_WE_reg_out_in && (bus.state_in == ST_COMPRESS);
    assign accept           = beat_in_compress && !fifo_full;
    assign drop             = beat_in_compress && fifo_full;

    ram2_index_writer_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (fifo_pop),
        .din   ({bus.RAM2_A_reg_out_in, bus.pos_bus_in}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_addr     = fifo_dout[ENTRY_W-1 -: ADDR_W];
    assign head_pos      = fifo_dout[POS_BUS_W-1:0];
    assign bus.stall_out = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + LANE_SUM_W'(bus.dist_bus_in[i*DIST_W +: DIST_W]);
        end
    end

    // Stage 1: byte serializer. Next-cycle outputs are decided here so the
    // RAM2 bus is registered; popping from S_B2 keeps beats back-to-back.
    always_comb begin
        ser_d    = ser_q;
        base_d   = base_p1;
        pos_d    = pos_p1;
        vld_d    = 1'b0;
        addr_d   = addr_p1;
        data_d   = data_p1;
        fifo_pop = 1'b0;
        case (ser_q)
            S_IDLE, S_B2: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    ser_d    = S_B0;
                    base_d   = times3(head_addr);
                    pos_d    = head_pos;
                    vld_d    = 1'b1;
                    addr_d   = times3(head_addr);
                    data_d   = head_pos[7:0];
                end else begin
                    ser_d = S_IDLE;
                end
            end
            S_B0: begin
                ser_d  = S_B1;
                vld_d  = 1'b1;
                addr_d = base_p1 + ADDR_W'(1);
                data_d = pos_p1[15:8];
            end
            S_B1: begin
                ser_d  = S_B2;
                vld_d  = 1'b1;
                addr_d = base_p1 + ADDR_W'(2);
                data_d = pos_p1[23:16];
            end
            default: ser_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_q   <= S_IDLE;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            ser_q   <= ser_d;
            vld_p1  <= vld_d;
            addr_p1 <= addr_d;
            data_p1 <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        base_p1 <= base_d;
        pos_p1  <= pos_d;
    end

    assign bus.RAM2_WE = vld_p1;
    assign bus.RAM2_A  = addr_p1;
    assign bus.RAM2_D  = data_p1;

    // Status: distortion accumulator, sticky overflow and one-shot done.
    // done fires when nothing is queued and the serializer is idle or
    // finishing its last byte, then stays quiet until FINISH is left.
    assign done_cond = (bus.state_in == ST_FINISH) && fifo_empty &&
                       ((ser_q == S_IDLE) || (ser_q == S_B2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q        <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            done_fired_q <= 1'b0;
        end else begin
            if (bus.state_in == ST_IDLE) sum_q <= '0;
            else if (accept)             sum_q <= sat_add(sum_q, lane_sum);

            if (bus.state_in == ST_IDLE) overflow_q <= 1'b0;
            else if (drop)               overflow_q <= 1'b1;

            done_q <= done_cond && !done_fired_q;
            if (bus.state_in != ST_FINISH) done_fired_q <= 1'b0;
            else if (done_cond)            done_fired_q <= 1'b1;
        end
    end

    assign bus.distortion_sum = sum_q;
    assign bus.overflow       = overflow_q;
    assign bus.done           = done_q;

endmodule
